// File: rtl/gemm_tile_sequencer_pkg.sv
// Shared configuration for the GEMM tile sequencer: register map, DIM field layout,
// FSM state encoding and small arithmetic helpers.
package gemm_tile_sequencer_pkg;

  localparam int SUPER_SYS_ROWS = 16;
  localparam int SUPER_SYS_COLS = 16;

  localparam logic [31:0] REG_AADR = 32'd0;
  localparam logic [31:0] REG_BADR = 32'd4;
  localparam logic [31:0] REG_CADR = 32'd8;
  localparam logic [31:0] REG_ASTR = 32'd12;
  localparam logic [31:0] REG_BSTR = 32'd16;
  localparam logic [31:0] REG_CTRL = 32'd20;
  localparam logic [31:0] REG_DIM  = 32'd24;
  // Status reads share offsets with the write registers: +0 reports full, +24 reports done.
  localparam logic [31:0] REG_FULL = 32'd0;
  localparam logic [31:0] REG_DONE = 32'd24;

  localparam int DIM_M_SHIFT = 0;
  localparam int DIM_K_SHIFT = 5;
  localparam int DIM_N_SHIFT = 10;

  typedef enum logic [3:0] {
    IDLE      = 4'd0,
    WR_ASTR   = 4'd1,
    WR_BSTR   = 4'd2,
    WR_AADR   = 4'd3,
    WR_BADR   = 4'd4,
    WR_CADR   = 4'd5,
    WR_CTRL   = 4'd6,
    WR_DIM    = 4'd7,
    POLL_FULL = 4'd8,
    POLL_DONE = 4'd9,
    FINISH    = 4'd10
  } state_e;

  function automatic logic [31:0] tile_size(input logic [31:0] pos, input logic [31:0] blk,
                                            input logic [31:0] dim);
    logic [31:0] sz;
    if (pos + blk <= dim) sz = blk;
    else                  sz = dim % blk;
    return sz;
  endfunction

  function automatic logic [31:0] pack_dim(input logic [31:0] ms, input logic [31:0] ks,
                                           input logic [31:0] ns);
    return (ms << DIM_M_SHIFT) | (ks << DIM_K_SHIFT) | (ns << DIM_N_SHIFT);
  endfunction

endpackage

// File: rtl/gemm_tile_addr_gen.sv
// Tile walker for the GEMM sequencer: holds the captured job and the n/m/k counters,
// and derives per-tile sizes, A/B/C addresses, first/last flags and end-of-walk flags.
module gemm_tile_addr_gen
  import gemm_tile_sequencer_pkg::*;
#(
  parameter int BLKM = 16,
  parameter int BLKN = SUPER_SYS_ROWS,
  parameter int BLKK = SUPER_SYS_COLS
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        load_i,
  input  logic        adv_i,
  input  logic [15:0] mat_m_i,
  input  logic [15:0] mat_k_i,
  input  logic [15:0] mat_n_i,
  input  logic [31:0] a_base_i,
  input  logic [31:0] b_base_i,
  input  logic [31:0] c_base_i,
  output logic [31:0] dim_k_o,
  output logic [31:0] dim_n_o,
  output logic [31:0] a_addr_o,
  output logic [31:0] b_addr_o,
  output logic [31:0] c_addr_o,
  output logic [31:0] ctrl_o,
  output logic [31:0] dim_word_o,
  output logic        last_mk_o,
  output logic        last_n_o
);

  localparam logic [31:0] BM   = 32'(BLKM);
  localparam logic [31:0] BN   = 32'(BLKN);
  localparam logic [31:0] BK   = 32'(BLKK);
  localparam logic [15:0] BM16 = 16'(BLKM);
  localparam logic [15:0] BN16 = 16'(BLKN);
  localparam logic [15:0] BK16 = 16'(BLKK);

  logic [15:0] m_q, m_d, n_q, n_d, k_q, k_d;
  logic [15:0] dm_q, dk_q, dn_q;
  logic [31:0] ab_q, bb_q, cb_q;
  logic [31:0] m_w, n_w, k_w, dm_w, dk_w, dn_w;
  logic [31:0] msize_s, nsize_s, ksize_s;
  logic        m_last_s, n_last_s, k_last_s;

  assign m_w  = {16'd0, m_q};
  assign n_w  = {16'd0, n_q};
  assign k_w  = {16'd0, k_q};
  assign dm_w = {16'd0, dm_q};
  assign dk_w = {16'd0, dk_q};
  assign dn_w = {16'd0, dn_q};

  assign m_last_s = (m_w + BM >= dm_w);
  assign n_last_s = (n_w + BN >= dn_w);
  assign k_last_s = (k_w + BK >= dk_w);

  assign msize_s = tile_size(m_w, BM, dm_w);
  assign nsize_s = tile_size(n_w, BN, dn_w);
  assign ksize_s = tile_size(k_w, BK, dk_w);

  // B points at the last row of the k slice, hence the (ksize-1)*N term.
  assign a_addr_o   = ab_q + k_w + m_w * dk_w;
  assign b_addr_o   = bb_q + n_w + k_w * dn_w + (ksize_s - 32'd1) * dn_w;
  assign c_addr_o   = cb_q + n_w + m_w * dn_w;
  assign ctrl_o     = {30'd0, (k_q == 16'd0), k_last_s};
  assign dim_word_o = pack_dim(msize_s, ksize_s, nsize_s);
  assign dim_k_o    = dk_w;
  assign dim_n_o    = dn_w;
  assign last_mk_o  = k_last_s & m_last_s;
  assign last_n_o   = n_last_s;

  // Counter advance: k innermost, then m, then n.
  always_comb begin
    m_d = m_q;
    n_d = n_q;
    k_d = k_q;
    if (load_i) begin
      m_d = 16'd0;
      n_d = 16'd0;
      k_d = 16'd0;
    end else if (adv_i) begin
      if (!k_last_s) begin
        k_d = k_q + BK16;
      end else if (!m_last_s) begin
        k_d = 16'd0;
        m_d = m_q + BM16;
      end else begin
        k_d = 16'd0;
        m_d = 16'd0;
        n_d = n_q + BN16;
      end
    end else begin
      k_d = k_q;
    end
  end

  // Counter and job-capture registers.
  always_ff @(posedge clk) begin
    if (rst) begin
      m_q  <= 16'd0;
      n_q  <= 16'd0;
      k_q  <= 16'd0;
      dm_q <= 16'd0;
      dk_q <= 16'd0;
      dn_q <= 16'd0;
      ab_q <= 32'd0;
      bb_q <= 32'd0;
      cb_q <= 32'd0;
    end else begin
      m_q <= m_d;
      n_q <= n_d;
      k_q <= k_d;
      if (load_i) begin
        dm_q <= mat_m_i;
        dk_q <= mat_k_i;
        dn_q <= mat_n_i;
        ab_q <= a_base_i;
        bb_q <= b_base_i;
        cb_q <= c_base_i;
      end
    end
  end

endmodule

// File: rtl/gemm_tile_sequencer.sv
// Walks a GEMM job tile by tile, programming the gemm register file over the system bus.
// Optional GEMM_SEQ_PERF_EN adds perf_cycles / perf_stalls counters.
module gemm_tile_sequencer
  import gemm_tile_sequencer_pkg::*;
#(
  parameter logic [31:0] BASE_ADDR = 32'h9000_0000,
  parameter int          BLKM      = 16,
  parameter int          BLKN      = SUPER_SYS_ROWS,
  parameter int          BLKK      = SUPER_SYS_COLS
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        start,
  input  logic [15:0] mat_m,
  input  logic [15:0] mat_k,
  input  logic [15:0] mat_n,
  input  logic [31:0] a_base,
  input  logic [31:0] b_base,
  input  logic [31:0] c_base,
  output logic        busy,
  output logic        done,
`ifdef GEMM_SEQ_PERF_EN
  output logic [31:0] perf_cycles,
  output logic [31:0] perf_stalls,
`endif
  output logic        system_bus_en,
  output logic        system_bus_rdwr,
  output logic [31:0] system_bus_addr,
  output logic [31:0] system_bus_wr_data,
  input  logic [31:0] system_bus_rd_data
);

  state_e      state_q, state_d;
  logic        start_ok_s, zero_dim_s, rd_one_s, adv_s;
  logic        busy_q, done_q;
  logic [31:0] addr_q, wdata_q;
  logic        bus_en_s, bus_rdwr_s;
  logic [31:0] bus_addr_s, bus_wdata_s;
  logic [31:0] dim_k_s, dim_n_s, a_addr_s, b_addr_s, c_addr_s, ctrl_s, dim_word_s;
  logic        last_mk_s, last_n_s;

  assign start_ok_s = start && (state_q == IDLE);
  assign zero_dim_s = (mat_m == 16'd0) || (mat_k == 16'd0) || (mat_n == 16'd0);
  assign rd_one_s   = (system_bus_rd_data == 32'd1);
  assign adv_s      = ((state_q == POLL_FULL) && !rd_one_s && !last_mk_s) ||
                      ((state_q == POLL_DONE) && rd_one_s && !last_n_s);

  gemm_tile_addr_gen #(
    .BLKM(BLKM),
    .BLKN(BLKN),
    .BLKK(BLKK)
  ) u_addr_gen (
    .clk       (clk),
    .rst       (rst),
    .load_i    (start_ok_s),
    .adv_i     (adv_s),
    .mat_m_i   (mat_m),
    .mat_k_i   (mat_k),
    .mat_n_i   (mat_n),
    .a_base_i  (a_base),
    .b_base_i  (b_base),
    .c_base_i  (c_base),
    .dim_k_o   (dim_k_s),
    .dim_n_o   (dim_n_s),
    .a_addr_o  (a_addr_s),
    .b_addr_o  (b_addr_s),
    .c_addr_o  (c_addr_s),
    .ctrl_o    (ctrl_s),
    .dim_word_o(dim_word_s),
    .last_mk_o (last_mk_s),
    .last_n_o  (last_n_s)
  );

  // State register plus registered status outputs and the bus hold registers.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
      addr_q  <= 32'd0;
      wdata_q <= 32'd0;
    end else begin
      state_q <= state_d;
      busy_q  <= (state_d != IDLE);
      done_q  <= (state_d == FINISH);
      addr_q  <= bus_addr_s;
      wdata_q <= bus_wdata_s;
    end
  end

  // Next-state logic; the poll states react to rd_data in the same cycle.
  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE: begin
        if (start) state_d = zero_dim_s ? FINISH : WR_ASTR;
        else       state_d = IDLE;
      end
      WR_ASTR: state_d = WR_BSTR;
      WR_BSTR: state_d = WR_AADR;
      WR_AADR: state_d = WR_BADR;
      WR_BADR: state_d = WR_CADR;
      WR_CADR: state_d = WR_CTRL;
      WR_CTRL: state_d = WR_DIM;
      WR_DIM:  state_d = POLL_FULL;
      POLL_FULL: begin
        if (rd_one_s)       state_d = POLL_FULL;
        else if (last_mk_s) state_d = POLL_DONE;
        else                state_d = WR_ASTR;
      end
      POLL_DONE: begin
        if (!rd_one_s)     state_d = POLL_DONE;
        else if (last_n_s) state_d = FINISH;
        else               state_d = WR_ASTR;
      end
      FINISH:  state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // Bus drive per state; address and write data hold whenever the bus is idle.
  always_comb begin
    bus_en_s    = 1'b0;
    bus_rdwr_s  = 1'b0;
    bus_addr_s  = addr_q;
    bus_wdata_s = wdata_q;
    case (state_q)
      WR_ASTR: begin
        bus_en_s = 1'b1; bus_rdwr_s = 1'b1;
        bus_addr_s = BASE_ADDR + REG_ASTR; bus_wdata_s = dim_k_s;
      end
      WR_BSTR: begin
        bus_en_s = 1'b1; bus_rdwr_s = 1'b1;
        bus_addr_s = BASE_ADDR + REG_BSTR; bus_wdata_s = dim_n_s;
      end
      WR_AADR: begin
        bus_en_s = 1'b1; bus_rdwr_s = 1'b1;
        bus_addr_s = BASE_ADDR + REG_AADR; bus_wdata_s = a_addr_s;
      end
      WR_BADR: begin
        bus_en_s = 1'b1; bus_rdwr_s = 1'b1;
        bus_addr_s = BASE_ADDR + REG_BADR; bus_wdata_s = b_addr_s;
      end
      WR_CADR: begin
        bus_en_s = 1'b1; bus_rdwr_s = 1'b1;
        bus_addr_s = BASE_ADDR + REG_CADR; bus_wdata_s = c_addr_s;
      end
      WR_CTRL: begin
        bus_en_s = 1'b1; bus_rdwr_s = 1'b1;
        bus_addr_s = BASE_ADDR + REG_CTRL; bus_wdata_s = ctrl_s;
      end
      WR_DIM: begin
        bus_en_s = 1'b1; bus_rdwr_s = 1'b1;
        bus_addr_s = BASE_ADDR + REG_DIM; bus_wdata_s = dim_word_s;
      end
      POLL_FULL: begin
        bus_en_s = 1'b1; bus_addr_s = BASE_ADDR + REG_FULL;
      end
      POLL_DONE: begin
        bus_en_s = 1'b1; bus_addr_s = BASE_ADDR + REG_DONE;
      end
      default: begin
        bus_en_s = 1'b0;
      end
    endcase
  end

  assign busy               = busy_q;
  assign done               = done_q;
  assign system_bus_en      = bus_en_s;
  assign system_bus_rdwr    = bus_rdwr_s;
  assign system_bus_addr    = bus_addr_s;
  assign system_bus_wr_data = bus_wdata_s;

`ifdef GEMM_SEQ_PERF_EN
  logic [31:0] perf_cycles_q, perf_stalls_q;
  logic        wait_s;

  assign wait_s = ((state_q == POLL_FULL) && rd_one_s) || ((state_q == POLL_DONE) && !rd_one_s);

  // Performance counters, restarted by each accepted job and frozen once idle.
  always_ff @(posedge clk) begin
    if (rst) begin
      perf_cycles_q <= 32'd0;
      perf_stalls_q <= 32'd0;
    end else if (start_ok_s) begin
      perf_cycles_q <= 32'd0;
      perf_stalls_q <= 32'd0;
    end else begin
      if (busy_q) perf_cycles_q <= perf_cycles_q + 32'd1;
      if (wait_s) perf_stalls_q <= perf_stalls_q + 32'd1;
    end
  end

  assign perf_cycles = perf_cycles_q;
  assign perf_stalls = perf_stalls_q;
`endif

endmodule

// File: tb/tb_gemm_tile_sequencer.sv
// Self-checking bench for gemm_tile_sequencer: a tile-walk reference model builds the
// expected bus transaction list, and a small gemm responder drives rd_data.
module tb_gemm_tile_sequencer;

  localparam logic [31:0] BASE = 32'h9000_0000;
  localparam int          BLK  = 16;

  typedef struct {
    logic        rdwr;
    logic [31:0] addr;
    logic [31:0] data;
  } txn_t;

  logic        clk = 1'b0;
  logic        rst, start;
  logic [15:0] mat_m, mat_k, mat_n;
  logic [31:0] a_base, b_base, c_base;
  logic        busy, done, bus_en, bus_rdwr;
  logic [31:0] bus_addr, bus_wdata, bus_rdata;
`ifdef GEMM_SEQ_PERF_EN
  logic [31:0] perf_cycles, perf_stalls;
`endif

  int   full_left = 0;
  int   done_left = 0;
  int   checks = 0;
  int   errors = 0;
  txn_t exp_q[$];

  always #5 clk = ~clk;

  gemm_tile_sequencer dut (
    .clk               (clk),
    .rst               (rst),
    .start             (start),
    .mat_m             (mat_m),
    .mat_k             (mat_k),
    .mat_n             (mat_n),
    .a_base            (a_base),
    .b_base            (b_base),
    .c_base            (c_base),
    .busy              (busy),
    .done              (done),
`ifdef GEMM_SEQ_PERF_EN
    .perf_cycles       (perf_cycles),
    .perf_stalls       (perf_stalls),
`endif
    .system_bus_en     (bus_en),
    .system_bus_rdwr   (bus_rdwr),
    .system_bus_addr   (bus_addr),
    .system_bus_wr_data(bus_wdata),
    .system_bus_rd_data(bus_rdata)
  );

  // gemm status responder: full while full_left>0, done once done_left reaches 0.
  always_comb begin
    bus_rdata = 32'd0;
    if (bus_en && !bus_rdwr && bus_addr == BASE)
      bus_rdata = (full_left != 0) ? 32'd1 : 32'd0;
    else if (bus_en && !bus_rdwr && bus_addr == BASE + 32'd24)
      bus_rdata = (done_left == 0) ? 32'd1 : 32'd0;
    else
      bus_rdata = 32'd0;
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic push(input logic rdwr, input logic [31:0] addr, input logic [31:0] data);
    txn_t t;
    t.rdwr = rdwr; t.addr = addr; t.data = data;
    exp_q.push_back(t);
  endtask

  // Reference: the full transaction list for one job, reads carrying the held write data.
  task automatic build_expected(input int mm, input int kk, input int nn, input logic [31:0] ab,
                                input logic [31:0] bb, input logic [31:0] cb,
                                input int fw, input int dw);
    bit          first_full = 1'b1;
    bit          first_done = 1'b1;
    logic [31:0] dimw = 32'd0;
    exp_q.delete();
    for (int n = 0; n < nn; n += BLK) begin
      int dreps;
      for (int m = 0; m < mm; m += BLK) begin
        for (int k = 0; k < kk; k += BLK) begin
          int ms, ks, ns, reps;
          ms = (mm - m < BLK) ? mm - m : BLK;
          ks = (kk - k < BLK) ? kk - k : BLK;
          ns = (nn - n < BLK) ? nn - n : BLK;
          dimw = 32'(ms + ks * 32 + ns * 1024);
          push(1'b1, BASE + 32'd12, 32'(kk));
          push(1'b1, BASE + 32'd16, 32'(nn));
          push(1'b1, BASE + 32'd0,  ab + 32'(k) + 32'(m * kk));
          push(1'b1, BASE + 32'd4,  bb + 32'(n) + 32'(k * nn) + 32'((ks - 1) * nn));
          push(1'b1, BASE + 32'd8,  cb + 32'(n) + 32'(m * nn));
          push(1'b1, BASE + 32'd20, {30'd0, (k == 0), (k + BLK >= kk)});
          push(1'b1, BASE + 32'd24, dimw);
          reps = first_full ? fw + 1 : 1;
          first_full = 1'b0;
          for (int r = 0; r < reps; r++) push(1'b0, BASE, dimw);
        end
      end
      dreps = first_done ? dw + 1 : 1;
      first_done = 1'b0;
      for (int r = 0; r < dreps; r++) push(1'b0, BASE + 32'd24, dimw);
    end
  endtask

  task automatic run_job(input string tag, input int mm, input int kk, input int nn,
                         input logic [31:0] ab, input logic [31:0] bb, input logic [31:0] cb,
                         input int fw, input int dw, input bit poke);
    int idx = 0;
    int cyc = 0;
    bit seen_done = 1'b0;
    bit fpoll, dpoll;
    build_expected(mm, kk, nn, ab, bb, cb, fw, dw);
    full_left = fw;
    done_left = dw;
    @(negedge clk);
    mat_m = 16'(mm); mat_k = 16'(kk); mat_n = 16'(nn);
    a_base = ab; b_base = bb; c_base = cb;
    start = 1'b1;
    @(posedge clk);
    #1 start = 1'b0;
    while (!seen_done && cyc < 4000) begin
      @(negedge clk);
      cyc++;
      if (cyc == 1) check({tag, "_busy_rise"}, {31'd0, busy}, 32'd1);
      if (poke && cyc == 3) begin
        start = 1'b1; mat_m = 16'd1; mat_n = 16'd0;
      end
      if (poke && cyc == 4) start = 1'b0;
      fpoll = bus_en && !bus_rdwr && bus_addr == BASE;
      dpoll = bus_en && !bus_rdwr && bus_addr == BASE + 32'd24;
      if (bus_en) begin
        if (idx < exp_q.size()) begin
          check({tag, "_rdwr"}, {31'd0, bus_rdwr}, {31'd0, exp_q[idx].rdwr});
          check({tag, "_addr"}, bus_addr, exp_q[idx].addr);
          check({tag, "_data"}, bus_wdata, exp_q[idx].data);
        end else begin
          check({tag, "_extra_txn"}, 32'(idx), 32'(exp_q.size()));
        end
        idx++;
      end
      if (done) begin
        seen_done = 1'b1;
        check({tag, "_done_cycle"}, 32'(cyc), 32'(exp_q.size() + 1));
        check({tag, "_busy_finish"}, {31'd0, busy}, 32'd1);
      end
      @(posedge clk);
      #1;
      if (fpoll && full_left > 0) full_left--;
      if (dpoll && done_left > 0) done_left--;
    end
    check({tag, "_timeout"}, {31'd0, seen_done}, 32'd1);
    check({tag, "_txn_count"}, 32'(idx), 32'(exp_q.size()));
    @(negedge clk);
    check({tag, "_idle_done"}, {31'd0, done}, 32'd0);
    check({tag, "_idle_busy"}, {31'd0, busy}, 32'd0);
    check({tag, "_idle_en"}, {31'd0, bus_en}, 32'd0);
    check({tag, "_idle_addr"}, bus_addr, BASE + 32'd24);
`ifdef GEMM_SEQ_PERF_EN
    check({tag, "_perf_cycles"}, perf_cycles, 32'(exp_q.size() + 1));
    check({tag, "_perf_stalls"}, perf_stalls, 32'(fw + dw));
`endif
  endtask

  initial begin
    rst = 1'b1; start = 1'b0;
    mat_m = 16'd0; mat_k = 16'd0; mat_n = 16'd0;
    a_base = 32'd0; b_base = 32'd0; c_base = 32'd0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    check("rst_busy", {31'd0, busy}, 32'd0);
    check("rst_done", {31'd0, done}, 32'd0);
    check("rst_en", {31'd0, bus_en}, 32'd0);
    check("rst_rdwr", {31'd0, bus_rdwr}, 32'd0);
    check("rst_addr", bus_addr, 32'd0);
    check("rst_wdata", bus_wdata, 32'd0);
    rst = 1'b0;

    // Zero-dimension job finishes on the next cycle with no bus traffic.
    @(negedge clk);
    mat_m = 16'd16; mat_k = 16'd16; mat_n = 16'd0; start = 1'b1;
    @(posedge clk);
    #1 start = 1'b0;
    @(negedge clk);
    check("zero_done", {31'd0, done}, 32'd1);
    check("zero_busy", {31'd0, busy}, 32'd1);
    check("zero_en", {31'd0, bus_en}, 32'd0);
    @(negedge clk);
    check("zero_done_clr", {31'd0, done}, 32'd0);
    check("zero_busy_clr", {31'd0, busy}, 32'd0);
    check("zero_en2", {31'd0, bus_en}, 32'd0);

    run_job("single", 16, 16, 16, 32'd0, 32'd256, 32'd512, 0, 2, 1'b0);
    run_job("ksplit", 16, 32, 16, 32'd0, 32'd256, 32'd512, 0, 0, 1'b0);
    run_job("mtail", 20, 16, 16, 32'd1000, 32'd2000, 32'd3000, 0, 1, 1'b0);
    run_job("fullhold", 16, 16, 16, 32'd0, 32'd256, 32'd512, 5, 0, 1'b1);

    // Reset in WR_BADR aborts the job; a fresh start re-runs it from tile 0.
    @(negedge clk);
    mat_m = 16'd32; mat_k = 16'd32; mat_n = 16'd16;
    a_base = 32'd0; b_base = 32'd256; c_base = 32'd512; start = 1'b1;
    @(posedge clk);
    #1 start = 1'b0;
    repeat (4) @(negedge clk);
    check("abort_at_badr", bus_addr, BASE + 32'd4);
    rst = 1'b1;
    @(posedge clk);
    #1 rst = 1'b0;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      check("abort_en", {31'd0, bus_en}, 32'd0);
      check("abort_done", {31'd0, done}, 32'd0);
      check("abort_busy", {31'd0, busy}, 32'd0);
    end
    run_job("rerun", 32, 32, 16, 32'd0, 32'd256, 32'd512, 1, 1, 1'b0);

    for (int j = 0; j < 6; j++) begin
      int rm, rk, rn;
      logic [31:0] ra, rb, rc;
      rm = int'($urandom_range(40, 1));
      rk = int'($urandom_range(40, 1));
      rn = int'($urandom_range(40, 1));
      ra = $urandom; rb = $urandom; rc = $urandom;
      run_job("random", rm, rk, rn, ra, rb, rc,
              int'($urandom_range(3, 0)), int'($urandom_range(3, 0)), 1'b0);
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/gemm_tile_sequencer.md
GEMM_TILE_SEQUENCER -- requirements
Module: gemm_tile_sequencer

Interface
REQ-001 SHALL have parameter BASE_ADDR, default 32'h9000_0000: GEMM register-file base on the system bus.
REQ-002 SHALL have parameter BLKM, default 16: tile rows per GEMM call.
REQ-003 SHALL have parameter BLKN, default SUPER_SYS_ROWS: tile columns per GEMM call.
REQ-004 SHALL have parameter BLKK, default SUPER_SYS_COLS: tile depth per GEMM call.
REQ-005 SHALL have ports: clk in 1 clock; rst in 1 reset. One clock; reset is synchronous and active-high.
REQ-006 SHALL have ports: start in 1 job strobe; mat_m, mat_k, mat_n in 16 each, matrix dims; a_base, b_base, c_base in 32 each, word addresses of A, B, C.
REQ-007 SHALL have ports: busy out 1, job active; done out 1, one-cycle completion pulse.
REQ-008 SHALL have ports: system_bus_en out 1; system_bus_rdwr out 1 (1=write); system_bus_addr out 32; system_bus_wr_data out 32; system_bus_rd_data in 32. These are the master side feeding gemm.

Function
REQ-009 SHALL sample the job inputs on start while IDLE; start while busy SHALL be ignored.
REQ-010 SHALL walk tiles in the order n outer (step BLKN), m middle (step BLKM), k inner (step BLKK).
REQ-011 SHALL compute sizes: msize = BLKM if m+BLKM<=M else M%BLKM; nsize and ksize the same way with BLKN/N and BLKK/K.
REQ-012 SHALL compute addresses: A_t = a_base+k+m*K; B_t = b_base+n+k*N+(ksize-1)*N; C_t = c_base+n+m*N, using 32-bit unsigned arithmetic with wrap.
REQ-013 SHALL set first = (k==0) and last = (k+BLKK>=K).
REQ-014 SHALL issue, per tile, one write per cycle, en=1 rdwr=1, in this order: +12 <= K; +16 <= N; +0 <= A_t; +4 <= B_t; +8 <= C_t; +20 <= {first,last} (bit1 first, bit0 last); +24 <= msize | ksize<<5 | nsize<<10.
REQ-015 State POLL_FULL SHALL drive en=1 rdwr=0 addr=BASE+0. It SHALL sample rd_data combinationally in the same cycle and remain while rd_data==1, otherwise advance to the next tile.
REQ-016 After the last m/k tile of each n column, state POLL_DONE SHALL read BASE+24 until rd_data==1, then start the next n column or finish.
REQ-017 States SHALL be IDLE, WR_ASTR, WR_BSTR, WR_AADR, WR_BADR, WR_CADR, WR_CTRL, WR_DIM, POLL_FULL, POLL_DONE, FINISH. FINISH SHALL pulse done for one cycle and return to IDLE.
REQ-018 system_bus_en SHALL be 0 in IDLE and FINISH; addr and wr_data SHALL hold their last values when en=0.
REQ-019 A start with any dim equal to 0 SHALL produce done on the next cycle with no bus traffic.
REQ-020 A single-tile job (M<=BLKM, K<=BLKK, N<=BLKN) SHALL issue exactly 7 writes with first=last=1, then POLL_FULL, then POLL_DONE.
REQ-021 busy SHALL be 1 from the cycle after an accepted start through the FINISH cycle inclusive.

Reset
REQ-022 On rst: state=IDLE; busy=0, done=0, system_bus_en=0, system_bus_rdwr=0, addr=0, wr_data=0; loop counters cleared.
REQ-023 rst asserted mid-job SHALL abort the job within the same edge, with no done pulse and no further bus cycles.

Configuration
REQ-024 Macro GEMM_SEQ_PERF_EN defined: SHALL add output perf_cycles [31:0] counting cycles with busy=1, cleared on accepted start, held after done, and output perf_stalls [31:0] counting POLL_FULL and POLL_DONE cycles with rd_data indicating wait.
REQ-025 Macro GEMM_SEQ_PERF_EN undefined: these ports and counters SHALL be absent; all other behaviour SHALL be identical.

Structure
REQ-026 The register offsets (0,4,8,12,16,20,24), the DIM field shifts (0,5,10) and the state enum SHALL live in the shared Config package.
REQ-027 A sub-module gemm_tile_addr_gen SHALL hold the n/m/k counters and produce sizes, addresses, first, last and last-tile flags. The FSM SHALL stay in the top module.

Verification
REQ-028 M=K=N=16, BLK*=16, a_base=0, b_base=256, c_base=512: exactly 7 writes with A_t=0, B_t=496, C_t=512, ctrl=3, dim=16|16<<5|16<<10; done after POLL_DONE reads 1.
REQ-029 M=16, K=32, N=16, BLKK=16: two tiles, ctrl=2 then 1; second tile A_t=16, B_t=256+16*16+15*16.
REQ-030 M=20, BLKM=16: second m tile msize=4, A_t=a_base+16*K.
REQ-031 gemm model holds full=1 for 5 cycles: sequencer stays in POLL_FULL with no writes and advances the cycle full drops.
REQ-032 rst pulsed during WR_BADR: en=0 next cycle, no done; a new start re-runs the job from tile 0.
REQ-033 start with N=0: done one cycle later, en never asserted; a start during busy is ignored.
